ring_nic: RTL and testbench
===========================

RING_NIC -- requirements
Module: ring_nic

Interface
REQ-001 Parameter NODE_ID, default 0, is this endpoint's ring node ID and the src stamp on every injected packet.
REQ-002 Parameter TXDEPTH, default 4, is the injection queue depth (power of 2).
REQ-003 Parameter RXDEPTH, default 4, is the ejection queue depth (power of 2).
REQ-004 Parameter STALL_LIMIT, default 64, is the consecutive unaccepted-offer cycles before tx_stall asserts.
REQ-005 clk  in  1  sole clock; all state updates on posedge clk.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 tx_valid  in  1  core offers a packet.
REQ-008 tx_ready  out  1  injection queue can accept; transfer occurs when tx_valid && tx_ready.
REQ-009 tx_dest  in  `ID_SIZE  destination node of the offered packet.
REQ-010 tx_data  in  `DATA_WIDTH  payload of the offered packet.
REQ-011 pkt_out  out  pkt_t  packet presented to the ring node's send input.
REQ-012 pkt_out_valid  out  1  drives the ring's core-inject strobe for this node.
REQ-013 pkt_accepted  in  1  ring's take-from-outside indication for this node, same cycle as the offer.
REQ-014 pkt_in  in  pkt_t  packet delivered by the ring node.
REQ-015 pkt_in_valid  in  1  ring delivered-packet strobe; no backpressure is possible.
REQ-016 rx_valid  out  1  ejection queue non-empty.
REQ-017 rx_ready  in  1  core consumes head; pop when rx_valid && rx_ready.
REQ-018 rx_src  out  `ID_SIZE  src field of the ejection head.
REQ-019 rx_data  out  `DATA_WIDTH  data field of the ejection head.
REQ-020 rx_drop_count  out  16  delivered packets dropped because the ejection queue was full; saturates at 16'hFFFF.
REQ-021 misroute_count  out  16  delivered packets whose dest != NODE_ID; saturates.
REQ-022 tx_stall  out  1  current offer unaccepted for >= STALL_LIMIT consecutive cycles.

Function
REQ-023 Enqueue stores {src=NODE_ID, dest=tx_dest, data=tx_data}; tx_ready = ~txq_full.
REQ-024 Injection FSM states: IDLE, OFFER, LOOP; in IDLE, txq non-empty with head.dest != NODE_ID -> OFFER; with head.dest == NODE_ID -> LOOP.
REQ-025 In OFFER, pkt_out = txq head and pkt_out_valid = 1, held stable every cycle until pkt_accepted.
REQ-026 In OFFER with pkt_accepted = 1: pop head that edge; go to IDLE (next offer no earlier than the following cycle).
REQ-027 In IDLE and LOOP, pkt_out_valid = 0 and pkt_out = '0.
REQ-028 LOOP writes the head directly into the ejection queue, bypassing the ring, on the first cycle with no ring push and rxq not full (or popping); then pops txq and goes to IDLE.
REQ-029 Ring push: pkt_in_valid && pkt_in.dest == NODE_ID writes pkt_in to the ejection queue; a ring push has priority over a LOOP write in the same cycle.
REQ-030 Ring push with rxq full and no same-cycle pop: packet dropped, rx_drop_count += 1 (saturating).
REQ-031 Ring push with rxq full and a same-cycle pop: push accepted, no drop.
REQ-032 pkt_in_valid with pkt_in.dest != NODE_ID: discarded, misroute_count += 1 (saturating).
REQ-033 Both queues: combinational read of head; simultaneous push/pop legal at any occupancy; pointer wrap natural at depth; occupancy counter one bit wider than the pointers.
REQ-034 Stall counter increments each OFFER cycle without pkt_accepted, saturating at STALL_LIMIT; tx_stall = (count == STALL_LIMIT); clears to 0 on accept or leaving OFFER.
REQ-035 Delivery order to the core equals ejection-queue push order; injection order equals enqueue order.

Reset
REQ-036 On reset: FSM = IDLE, both queues empty, all pointers/counters 0; tx_ready = 1, pkt_out_valid = 0, rx_valid = 0, tx_stall = 0, both 16-bit counters = 0.
REQ-037 Reset mid-offer or mid-loop discards all queued packets; reset dominates every other input that cycle.

Structure
REQ-038 pkt_t and `ID_SIZE/`DATA_WIDTH/`NUMNODES come from the shared network package/header; the FSM state enum is added to that package.
REQ-039 One sub-module, nic_fifo (parameterised WIDTH, HEIGHT, synchronous active-high reset, combinational head), is instantiated twice.

Verification
REQ-040 NODE_ID=1: enqueue dest=2, data=128'h1234; hold pkt_accepted=0 for 3 cycles -> pkt_out stable {1,2,1234} all 3 cycles; accept on 4th -> pop, pkt_out_valid=0 next cycle.
REQ-041 pkt_accepted=0 held for 70 cycles -> tx_stall rises on cycle 64 of the offer, clears the cycle after acceptance.
REQ-042 RXDEPTH=4, rx_ready=0, deliver 6 packets to NODE_ID -> rx_valid=1, rx_drop_count=2, the first 4 drained in order.
REQ-043 rxq full, rx_ready=1, and pkt_in_valid in the same cycle -> no drop, occupancy stays 4.
REQ-044 Enqueue dest=NODE_ID while ring pushes every cycle for 3 cycles -> LOOP waits, writes on cycle 4, pkt_out_valid never asserts.
REQ-045 pkt_in.dest=3 at NODE_ID=1 -> misroute_count=1, rx_valid stays 0; assert reset while in OFFER -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/ring_nic_pkg.sv
// ring_nic_pkg: shared network types and injection FSM states
package ring_nic_pkg;
  localparam int ID_SIZE = 4;
  localparam int DATA_WIDTH = 128;
  localparam int NUMNODES = 16;
  typedef struct packed {
    logic [ID_SIZE-1:0] src;
    logic [ID_SIZE-1:0] dest;
    logic [DATA_WIDTH-1:0] data;
  } pkt_t;
  typedef enum logic [1:0] {IDLE, OFFER, LOOP} inj_state_t;
endpackage

// File: rtl/ring_nic_fifo.sv
// nic_fifo: synchronous FIFO with combinational head and push/pop at any occupancy
module nic_fifo #(
  parameter int WIDTH = 8,
  parameter int HEIGHT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(HEIGHT);
  logic [WIDTH-1:0] mem_q [HEIGHT];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == (PW+1)'(HEIGHT);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    dout = mem_q[rd_ptr_q];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/ring_nic.sv
// ring_nic: ring network endpoint with injection/ejection queues, local loopback and error counters
import ring_nic_pkg::*;
module ring_nic #(
  parameter int NODE_ID = 0,
  parameter int TXDEPTH = 4,
  parameter int RXDEPTH = 4,
  parameter int STALL_LIMIT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [ID_SIZE-1:0]    tx_dest,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output pkt_t                  pkt_out,
  output logic                  pkt_out_valid,
  input  logic                  pkt_accepted,
  input  pkt_t                  pkt_in,
  input  logic                  pkt_in_valid,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [ID_SIZE-1:0]    rx_src,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic [15:0]           rx_drop_count,
  output logic [15:0]           misroute_count,
  output logic                  tx_stall
);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam int RW = ID_SIZE + DATA_WIDTH;
  localparam logic [ID_SIZE-1:0] OWN = ID_SIZE'(NODE_ID);
  inj_state_t state_q, state_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [15:0] drop_q, drop_d, mis_q, mis_d;
  pkt_t tx_din, tx_head;
  logic [RW-1:0] rx_din, rx_head;
  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic ring_push, loop_wr, drop, misroute;
  nic_fifo #(.WIDTH($bits(pkt_t)), .HEIGHT(TXDEPTH)) u_txq (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .din(tx_din),
    .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );
  nic_fifo #(.WIDTH(RW), .HEIGHT(RXDEPTH)) u_rxq (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .din(rx_din),
    .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );
  always_comb begin
    tx_ready = !tx_full;
    tx_push = tx_valid && tx_ready;
    tx_din = '{src: OWN, dest: tx_dest, data: tx_data};
    rx_valid = !rx_empty;
    {rx_src, rx_data} = rx_head;
    rx_pop = rx_valid && rx_ready;
    ring_push = pkt_in_valid && pkt_in.dest == OWN;
    misroute = pkt_in_valid && pkt_in.dest != OWN;
    loop_wr = state_q == LOOP && !ring_push && (!rx_full || rx_pop);
    rx_push = ring_push || loop_wr;
    rx_din = ring_push ? {pkt_in.src, pkt_in.data} : {tx_head.src, tx_head.data};
    drop = ring_push && rx_full && !rx_pop;
    tx_pop = (state_q == OFFER && pkt_accepted) || loop_wr;
    state_d = state_q == IDLE ? (tx_empty ? IDLE : (tx_head.dest == OWN ? LOOP : OFFER))
            : tx_pop ? IDLE : state_q;
    tx_stall = stall_q == SW'(STALL_LIMIT);
    stall_d = (state_q == OFFER && !pkt_accepted) ? (tx_stall ? stall_q : stall_q + 1'b1) : '0;
    drop_d = (drop && !(&drop_q)) ? drop_q + 16'd1 : drop_q;
    mis_d = (misroute && !(&mis_q)) ? mis_q + 16'd1 : mis_q;
    pkt_out_valid = state_q == OFFER;
    pkt_out = pkt_out_valid ? tx_head : '0;
    rx_drop_count = drop_q;
    misroute_count = mis_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      stall_q <= '0;
      drop_q <= '0;
      mis_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      drop_q <= drop_d;
      mis_q <= mis_d;
    end
  end
endmodule

// File: tb/tb_ring_nic.sv
// tb_ring_nic: directed and randomized self-checking bench for ring_nic against a queue model
import ring_nic_pkg::*;
module tb_ring_nic;
  localparam logic [ID_SIZE-1:0] ME = 4'd1;
  localparam int STALL = 64;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1;
  logic tx_valid, tx_ready, pkt_out_valid, pkt_accepted, pkt_in_valid, rx_valid, rx_ready, tx_stall;
  logic [ID_SIZE-1:0] tx_dest, rx_src;
  logic [DATA_WIDTH-1:0] tx_data, rx_data;
  logic [15:0] rx_drop_count, misroute_count;
  pkt_t pkt_out, pkt_in;
  int vectors = 0, miscompares = 0;
  ring_nic #(.NODE_ID(1), .TXDEPTH(DEPTH), .RXDEPTH(DEPTH), .STALL_LIMIT(STALL)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest(tx_dest),
    .tx_data(tx_data), .pkt_out(pkt_out), .pkt_out_valid(pkt_out_valid),
    .pkt_accepted(pkt_accepted), .pkt_in(pkt_in), .pkt_in_valid(pkt_in_valid),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src(rx_src), .rx_data(rx_data),
    .rx_drop_count(rx_drop_count), .misroute_count(misroute_count), .tx_stall(tx_stall)
  );
  always #5 clk = ~clk;
  function automatic logic [DATA_WIDTH-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    tx_valid = 0; tx_dest = '0; tx_data = '0; pkt_accepted = 0;
    pkt_in = '0; pkt_in_valid = 0; rx_ready = 0;
  endtask
  task automatic do_reset();
    idle_in();
    reset = 1;
    tick();
    reset = 0;
  endtask
  task automatic test_reset();
    do_reset();
    vectors++;
    if ({tx_ready, pkt_out_valid, rx_valid, tx_stall} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_flags got %b expected 1000", {tx_ready, pkt_out_valid, rx_valid, tx_stall});
    end
    vectors++;
    if (rx_drop_count !== 16'd0 || misroute_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_counters got drop=%0d mis=%0d expected 0/0", rx_drop_count, misroute_count);
    end
    vectors++;
    if (pkt_out !== '0) begin
      miscompares++;
      $display("FAIL reset_pkt_out got %h expected 0", pkt_out);
    end
  endtask
  task automatic test_offer_hold();
    pkt_t exp;
    do_reset();
    exp = '{src: ME, dest: 4'd2, data: 128'h1234};
    tx_valid = 1; tx_dest = 4'd2; tx_data = 128'h1234;
    tick();
    tx_valid = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (pkt_out_valid !== 1'b1 || pkt_out !== exp) begin
        miscompares++;
        $display("FAIL offer_hold cycle %0d got valid=%b pkt=%h expected 1 %h", i, pkt_out_valid, pkt_out, exp);
      end
      tick();
    end
    pkt_accepted = 1;
    vectors++;
    if (pkt_out_valid !== 1'b1 || pkt_out !== exp) begin
      miscompares++;
      $display("FAIL offer_accept_cycle got valid=%b pkt=%h expected 1 %h", pkt_out_valid, pkt_out, exp);
    end
    tick();
    pkt_accepted = 0;
    vectors++;
    if (pkt_out_valid !== 1'b0 || pkt_out !== '0) begin
      miscompares++;
      $display("FAIL offer_after_accept got valid=%b pkt=%h expected 0 0", pkt_out_valid, pkt_out);
    end
  endtask
  task automatic test_stall();
    logic exp;
    do_reset();
    tx_valid = 1; tx_dest = 4'd3; tx_data = rnd128();
    tick();
    tx_valid = 0;
    tick();
    for (int n = 0; n < 70; n++) begin
      exp = n >= STALL;
      vectors++;
      if (tx_stall !== exp) begin
        miscompares++;
        $display("FAIL stall_count after %0d unaccepted cycles got %b expected %b", n, tx_stall, exp);
      end
      tick();
    end
    pkt_accepted = 1;
    vectors++;
    if (tx_stall !== 1'b1 || pkt_out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_held got stall=%b valid=%b expected 1 1", tx_stall, pkt_out_valid);
    end
    tick();
    pkt_accepted = 0;
    vectors++;
    if (tx_stall !== 1'b0 || pkt_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_clear got stall=%b valid=%b expected 0 0", tx_stall, pkt_out_valid);
    end
  endtask
  task automatic test_rx_overflow();
    logic [ID_SIZE+DATA_WIDTH-1:0] q[$];
    int exp_drop = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      pkt_in_valid = 1;
      pkt_in = '{src: 4'($urandom), dest: ME, data: rnd128()};
      if (q.size() < DEPTH) q.push_back({pkt_in.src, pkt_in.data});
      else exp_drop++;
      tick();
    end
    pkt_in_valid = 0;
    vectors++;
    if (rx_valid !== 1'b1 || rx_drop_count !== 16'(exp_drop)) begin
      miscompares++;
      $display("FAIL overflow_drop got valid=%b drop=%0d expected 1 %0d", rx_valid, rx_drop_count, exp_drop);
    end
    rx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({rx_src, rx_data} !== q[0]) begin
        miscompares++;
        $display("FAIL overflow_order entry %0d got %h expected %h", i, {rx_src, rx_data}, q[0]);
      end
      void'(q.pop_front());
      tick();
    end
    rx_ready = 0;
    vectors++;
    if (rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_empty got rx_valid=%b expected 0", rx_valid);
    end
  endtask
  task automatic test_full_pushpop();
    logic [ID_SIZE+DATA_WIDTH-1:0] q[$];
    int n = 0;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      pkt_in_valid = 1;
      pkt_in = '{src: 4'($urandom), dest: ME, data: rnd128()};
      q.push_back({pkt_in.src, pkt_in.data});
      tick();
    end
    pkt_in = '{src: 4'($urandom), dest: ME, data: rnd128()};
    rx_ready = 1;
    void'(q.pop_front());
    q.push_back({pkt_in.src, pkt_in.data});
    tick();
    pkt_in_valid = 0;
    vectors++;
    if (rx_drop_count !== 16'd0) begin
      miscompares++;
      $display("FAIL full_pushpop_drop got %0d expected 0", rx_drop_count);
    end
    for (int i = 0; i < 8 && rx_valid; i++) begin
      vectors++;
      if (q.size() == 0 || {rx_src, rx_data} !== q[0]) begin
        miscompares++;
        $display("FAIL full_pushpop_order entry %0d got %h expected %h", i, {rx_src, rx_data}, q.size() ? q[0] : '0);
      end
      if (q.size()) void'(q.pop_front());
      n++;
      tick();
    end
    rx_ready = 0;
    vectors++;
    if (n != DEPTH) begin
      miscompares++;
      $display("FAIL full_pushpop_occupancy got %0d expected %0d", n, DEPTH);
    end
  endtask
  task automatic test_loop();
    logic [ID_SIZE+DATA_WIDTH-1:0] q[$];
    logic [DATA_WIDTH-1:0] d;
    int n = 0;
    do_reset();
    d = rnd128();
    tx_valid = 1; tx_dest = ME; tx_data = d;
    tick();
    tx_valid = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      pkt_in_valid = 1;
      pkt_in = '{src: 4'($urandom), dest: ME, data: rnd128()};
      q.push_back({pkt_in.src, pkt_in.data});
      vectors++;
      if (pkt_out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL loop_no_offer cycle %0d got %b expected 0", i, pkt_out_valid);
      end
      tick();
    end
    pkt_in_valid = 0;
    tick();
    q.push_back({ME, d});
    vectors++;
    if (pkt_out_valid !== 1'b0 || tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL loop_done got valid=%b tx_ready=%b expected 0 1", pkt_out_valid, tx_ready);
    end
    rx_ready = 1;
    for (int i = 0; i < 8 && rx_valid; i++) begin
      vectors++;
      if (q.size() == 0 || {rx_src, rx_data} !== q[0]) begin
        miscompares++;
        $display("FAIL loop_order entry %0d got %h expected %h", i, {rx_src, rx_data}, q.size() ? q[0] : '0);
      end
      if (q.size()) void'(q.pop_front());
      n++;
      tick();
    end
    rx_ready = 0;
    vectors++;
    if (n != 4) begin
      miscompares++;
      $display("FAIL loop_count got %0d expected 4", n);
    end
  endtask
  task automatic test_misroute_reset();
    do_reset();
    pkt_in_valid = 1;
    pkt_in = '{src: 4'd2, dest: 4'd3, data: rnd128()};
    tick();
    pkt_in_valid = 0;
    vectors++;
    if (misroute_count !== 16'd1 || rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL misroute got count=%0d rx_valid=%b expected 1 0", misroute_count, rx_valid);
    end
    tx_valid = 1; tx_dest = 4'd2; tx_data = rnd128();
    tick();
    tick();
    tx_valid = 0;
    vectors++;
    if (pkt_out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL misroute_offer got %b expected 1", pkt_out_valid);
    end
    reset = 1; tx_valid = 1; pkt_in_valid = 1;
    pkt_in = '{src: 4'd0, dest: ME, data: rnd128()};
    tick();
    reset = 0;
    idle_in();
    vectors++;
    if ({tx_ready, pkt_out_valid, rx_valid, tx_stall} !== 4'b1000 || pkt_out !== '0
        || rx_drop_count !== 16'd0 || misroute_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_mid_offer got flags=%b pkt=%h drop=%0d mis=%0d expected 1000 0 0 0",
               {tx_ready, pkt_out_valid, rx_valid, tx_stall}, pkt_out, rx_drop_count, misroute_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (pkt_out_valid !== 1'b0 || rx_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_discard cycle %0d got valid=%b rx_valid=%b expected 0 0", i, pkt_out_valid, rx_valid);
      end
    end
  endtask
  task automatic test_random();
    pkt_t txm[$];
    logic [ID_SIZE+DATA_WIDTH-1:0] rxm[$];
    int exp_drop = 0, exp_mis = 0;
    int d;
    logic push_ok, rpop;
    do_reset();
    for (int c = 0; c < 700; c++) begin
      if (c < 600) begin
        tx_valid = $urandom_range(0, 1);
        d = $urandom_range(0, 2);
        tx_dest = d == 0 ? 4'd0 : 4'(d + 1);
        tx_data = rnd128();
        pkt_accepted = $urandom_range(0, 2) != 0;
        pkt_in_valid = $urandom_range(0, 1);
        pkt_in = '{src: 4'($urandom), dest: 4'($urandom_range(0, 3)), data: rnd128()};
        rx_ready = $urandom_range(0, 1);
      end else begin
        tx_valid = 0; pkt_accepted = 1; pkt_in_valid = 0; rx_ready = 1;
      end
      vectors++;
      if (tx_ready !== (txm.size() < DEPTH) || rx_valid !== (rxm.size() != 0)) begin
        miscompares++;
        $display("FAIL rand_ready cycle %0d got tx_ready=%b rx_valid=%b expected %b %b",
                 c, tx_ready, rx_valid, txm.size() < DEPTH, rxm.size() != 0);
      end
      if (rxm.size() != 0) begin
        vectors++;
        if ({rx_src, rx_data} !== rxm[0]) begin
          miscompares++;
          $display("FAIL rand_rx_head cycle %0d got %h expected %h", c, {rx_src, rx_data}, rxm[0]);
        end
      end
      vectors++;
      if (rx_drop_count !== 16'(exp_drop) || misroute_count !== 16'(exp_mis)) begin
        miscompares++;
        $display("FAIL rand_counters cycle %0d got drop=%0d mis=%0d expected %0d %0d",
                 c, rx_drop_count, misroute_count, exp_drop, exp_mis);
      end
      vectors++;
      if (pkt_out_valid ? (txm.size() == 0 || pkt_out !== txm[0]) : pkt_out !== '0) begin
        miscompares++;
        $display("FAIL rand_pkt_out cycle %0d got valid=%b pkt=%h expected %h",
                 c, pkt_out_valid, pkt_out, txm.size() ? txm[0] : '0);
      end
      push_ok = txm.size() < DEPTH;
      if (pkt_out_valid && pkt_accepted && txm.size()) void'(txm.pop_front());
      if (tx_valid && push_ok) txm.push_back('{src: ME, dest: tx_dest, data: tx_data});
      rpop = rx_ready && rxm.size() != 0;
      if (pkt_in_valid && pkt_in.dest == ME) begin
        if (rxm.size() < DEPTH || rpop) rxm.push_back({pkt_in.src, pkt_in.data});
        else exp_drop++;
      end else if (pkt_in_valid) exp_mis++;
      if (rpop) void'(rxm.pop_front());
      tick();
    end
    vectors++;
    if (txm.size() != 0 || tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rand_tx_drain got %0d queued tx_ready=%b expected 0 1", txm.size(), tx_ready);
    end
    idle_in();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
  initial begin
    idle_in();
    test_reset();
    test_offer_hold();
    test_stall();
    test_rx_overflow();
    test_full_pushpop();
    test_loop();
    test_misroute_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
